// File: rtl/lsq_circ_if.sv
// Load/store queue port bundle: dispatch alloc, writeback buses,
// head/commit view and violation report.
interface lsq_circ_if #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 64,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ROB_W  = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              alloc_valid;
  logic              alloc_ready;
  logic              alloc_is_load;
  logic [PC_W-1:0]   alloc_pc;
  logic [ROB_W-1:0]  alloc_rob;
  logic              addr_valid;
  logic [ROB_W-1:0]  addr_rob;
  logic [ADDR_W-1:0] addr_data;
  logic              val_valid;
  logic [ROB_W-1:0]  val_rob;
  logic [DATA_W-1:0] val_data;
  logic              ldx_valid;
  logic [ROB_W-1:0]  ldx_rob;
  logic              head_valid;
  logic              head_is_load;
  logic [ROB_W-1:0]  head_rob;
  logic [PC_W-1:0]   head_pc;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              retire;
  logic              viol_valid;
  logic [PC_W-1:0]   viol_pc;
  logic [ROB_W-1:0]  viol_rob;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, alloc_valid, alloc_is_load, alloc_pc, alloc_rob,
    output addr_valid, addr_rob, addr_data,
    output val_valid, val_rob, val_data,
    output ldx_valid, ldx_rob, retire,
    input  alloc_ready, head_valid, head_is_load, head_rob,
    input  head_pc, head_addr, head_data,
    input  viol_valid, viol_pc, viol_rob, count
  );

  modport slave (
    input  flush, alloc_valid, alloc_is_load, alloc_pc, alloc_rob,
    input  addr_valid, addr_rob, addr_data,
    input  val_valid, val_rob, val_data,
    input  ldx_valid, ldx_rob, retire,
    output alloc_ready, head_valid, head_is_load, head_rob,
    output head_pc, head_addr, head_data,
    output viol_valid, viol_pc, viol_rob, count
  );
endinterface

// File: rtl/lsq_circ.sv
// Circular load/store queue: in-order alloc/commit, tag-CAM writebacks,
// store->load ordering violation detection.
module lsq_circ #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 64,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ROB_W  = 5
) (
  input logic       clk,
  input logic       reset,
  lsq_circ_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef struct packed {
    logic              valid;
    logic              is_load;
    logic [PC_W-1:0]   pc;
    logic [ROB_W-1:0]  rob;
    logic              addr_v;
    logic [ADDR_W-1:0] addr;
    logic              val_v;
    logic [DATA_W-1:0] data;
    logic              exec;
  } entry_t;

  entry_t q     [DEPTH];
  entry_t q_nxt [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] cnt;
  logic [IDX_W-1:0] h_idx;
  logic [IDX_W-1:0] t_idx;
  logic             full;
  logic             head_ok;
  logic             alloc_fire;
  logic             ret_fire;
  entry_t           hd;
  entry_t           new_e;

  logic             found_s;
  logic             found_l;
  logic [PC_W-1:0]  v_pc;
  logic [ROB_W-1:0] v_rob;
  logic [IDX_W-1:0] s_idx;
  entry_t           s_e;

  logic             viol_q;
  logic [PC_W-1:0]  viol_pc_q;
  logic [ROB_W-1:0] viol_rob_q;

  assign h_idx = head[IDX_W-1:0];
  assign t_idx = tail[IDX_W-1:0];
  assign full  = (cnt == PTR_W'(DEPTH));
  assign hd    = q[h_idx];

  assign head_ok = hd.valid & hd.addr_v &
                   (hd.is_load ? hd.exec : hd.val_v);

  assign alloc_fire = bus.alloc_valid & ~full & ~bus.flush;
  assign ret_fire   = bus.retire & head_ok & ~bus.flush;

  assign bus.alloc_ready  = ~full;
  assign bus.head_valid   = head_ok;
  assign bus.head_is_load = hd.is_load;
  assign bus.head_rob     = hd.rob;
  assign bus.head_pc      = hd.pc;
  assign bus.head_addr    = hd.addr;
  assign bus.head_data    = hd.data;
  assign bus.viol_valid   = viol_q;
  assign bus.viol_pc      = viol_pc_q;
  assign bus.viol_rob     = viol_rob_q;
  assign bus.count        = cnt;

  // Freed slots are zeroed so the head view reads 0 when empty.
  always_comb begin
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.is_load = bus.alloc_is_load;
    new_e.pc      = bus.alloc_pc;
    new_e.rob     = bus.alloc_rob;
    for (int i = 0; i < DEPTH; i++) begin
      q_nxt[i] = q[i];
      if (q[i].valid) begin
        if (bus.addr_valid && q[i].rob == bus.addr_rob) begin
          q_nxt[i].addr_v = 1'b1;
          q_nxt[i].addr   = bus.addr_data;
        end
        if (bus.val_valid && !q[i].is_load &&
            q[i].rob == bus.val_rob) begin
          q_nxt[i].val_v = 1'b1;
          q_nxt[i].data  = bus.val_data;
        end
        if (bus.ldx_valid && q[i].is_load &&
            q[i].rob == bus.ldx_rob) begin
          q_nxt[i].exec = 1'b1;
        end
      end
    end
    if (ret_fire) begin
      q_nxt[h_idx] = '0;
    end
    if (alloc_fire) begin
      q_nxt[t_idx] = new_e;
    end
  end

  // Walk from head in age order: first the store hit by the address
  // writeback, then the oldest younger executed load at that address.
  always_comb begin
    found_s = 1'b0;
    found_l = 1'b0;
    v_pc    = '0;
    v_rob   = '0;
    s_idx   = '0;
    s_e     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      s_idx = h_idx + IDX_W'(k);
      s_e   = q[s_idx];
      if (s_e.valid) begin
        if (!found_s) begin
          if (bus.addr_valid && !s_e.is_load &&
              s_e.rob == bus.addr_rob) begin
            found_s = 1'b1;
          end
        end else if (!found_l && s_e.is_load && s_e.addr_v &&
                     s_e.exec && s_e.addr == bus.addr_data) begin
          found_l = 1'b1;
          v_pc    = s_e.pc;
          v_rob   = s_e.rob;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      viol_q     <= 1'b0;
      viol_pc_q  <= '0;
      viol_rob_q <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      head   <= '0;
      tail   <= '0;
      cnt    <= '0;
      viol_q <= 1'b0;
    end else begin
      q <= q_nxt;
      if (ret_fire) begin
        head <= head + PTR_W'(1);
      end
      if (alloc_fire) begin
        tail <= tail + PTR_W'(1);
      end
      if (alloc_fire && !ret_fire) begin
        cnt <= cnt + PTR_W'(1);
      end else if (ret_fire && !alloc_fire) begin
        cnt <= cnt - PTR_W'(1);
      end
      viol_q <= found_l;
      if (found_l) begin
        viol_pc_q  <= v_pc;
        viol_rob_q <= v_rob;
      end
    end
  end
endmodule

// File: tb/tb_lsq_circ.sv
// Directed bench for lsq_circ: fill/drain, writebacks, violations,
// flush priority and pointer wrap.
module tb_lsq_circ;
  localparam int DEPTH  = 16;
  localparam int PC_W   = 64;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int ROB_W  = 5;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  lsq_circ_if #(
    .DEPTH(DEPTH), .PC_W(PC_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .ROB_W(ROB_W)
  ) bus ();

  lsq_circ #(
    .DEPTH(DEPTH), .PC_W(PC_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .ROB_W(ROB_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.flush         = 1'b0;
    bus.alloc_valid   = 1'b0;
    bus.alloc_is_load = 1'b0;
    bus.alloc_pc      = '0;
    bus.alloc_rob     = '0;
    bus.addr_valid    = 1'b0;
    bus.addr_rob      = '0;
    bus.addr_data     = '0;
    bus.val_valid     = 1'b0;
    bus.val_rob       = '0;
    bus.val_data      = '0;
    bus.ldx_valid     = 1'b0;
    bus.ldx_rob       = '0;
    bus.retire        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic alloc(input logic ld, input logic [63:0] pc,
                       input logic [4:0] rob);
    bus.alloc_valid   = 1'b1;
    bus.alloc_is_load = ld;
    bus.alloc_pc      = pc;
    bus.alloc_rob     = rob;
  endtask

  task automatic addr_wb(input logic [4:0] rob, input logic [63:0] a);
    bus.addr_valid = 1'b1;
    bus.addr_rob   = rob;
    bus.addr_data  = a;
  endtask

  task automatic val_wb(input logic [4:0] rob, input logic [63:0] d);
    bus.val_valid = 1'b1;
    bus.val_rob   = rob;
    bus.val_data  = d;
  endtask

  task automatic ldx(input logic [4:0] rob);
    bus.ldx_valid = 1'b1;
    bus.ldx_rob   = rob;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
  endtask

  initial begin
    int nxt;
    int ret_n;
    int mcnt;
    int pend;
    int wbdone;
    int cyc;
    logic do_ret;
    logic do_al;

    checks = 0;
    errors = 0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_count", 64'(bus.count), 0);
    chk("rst_ready", 64'(bus.alloc_ready), 1);
    chk("rst_hv", 64'(bus.head_valid), 0);
    chk("rst_hpc", bus.head_pc, 0);
    chk("rst_viol", 64'(bus.viol_valid), 0);
    chk("rst_vpc", bus.viol_pc, 0);
    chk("rst_vrob", 64'(bus.viol_rob), 0);

    // fill / drain
    for (int i = 0; i < 16; i++) begin
      alloc(1'b0, 64'h1000 + 64'(4 * i), 5'(i));
      tick();
    end
    chk("fill_count", 64'(bus.count), 16);
    chk("fill_ready", 64'(bus.alloc_ready), 0);
    alloc(1'b0, 64'h9999, 5'd20);
    tick();
    chk("full_ign_cnt", 64'(bus.count), 16);
    chk("full_ign_head", 64'(bus.head_rob), 0);
    addr_wb(5'd0, 64'h500);
    val_wb(5'd0, 64'hdead);
    tick();
    chk("fill_hv", 64'(bus.head_valid), 1);
    chk("fill_haddr", bus.head_addr, 64'h500);
    chk("fill_hdata", bus.head_data, 64'hdead);
    bus.retire = 1'b1;
    alloc(1'b0, 64'h7777, 5'd21);
    tick();
    chk("ret_full_cnt", 64'(bus.count), 15);
    chk("ret_full_rdy", 64'(bus.alloc_ready), 1);
    chk("ret_head", 64'(bus.head_rob), 1);
    bus.retire = 1'b1;
    tick();
    chk("ret_nv_cnt", 64'(bus.count), 15);
    do_flush();
    chk("fl1_count", 64'(bus.count), 0);
    chk("fl1_hv", 64'(bus.head_valid), 0);

    // out-of-order writeback
    alloc(1'b1, 64'h30, 5'd3);
    tick();
    alloc(1'b0, 64'h34, 5'd4);
    tick();
    addr_wb(5'd4, 64'h300);
    tick();
    chk("ooo_hv0", 64'(bus.head_valid), 0);
    addr_wb(5'd3, 64'h100);
    ldx(5'd3);
    val_wb(5'd3, 64'h77);
    tick();
    chk("ooo_hv1", 64'(bus.head_valid), 1);
    chk("ooo_hrob", 64'(bus.head_rob), 3);
    chk("ooo_haddr", bus.head_addr, 64'h100);
    chk("ooo_hld", 64'(bus.head_is_load), 1);
    chk("ooo_val_ld", bus.head_data, 0);
    bus.retire = 1'b1;
    tick();
    chk("ooo_st_rob", 64'(bus.head_rob), 4);
    chk("ooo_st_hv", 64'(bus.head_valid), 0);
    ldx(5'd4);
    tick();
    chk("ldx_st_ign", 64'(bus.head_valid), 0);
    val_wb(5'd4, 64'h44);
    tick();
    chk("st_hv", 64'(bus.head_valid), 1);
    chk("st_hdata", bus.head_data, 64'h44);
    do_flush();

    // writeback to a tag allocated in the same cycle
    alloc(1'b1, 64'h90, 5'd9);
    addr_wb(5'd9, 64'h99);
    tick();
    ldx(5'd9);
    tick();
    chk("same_cyc_hv", 64'(bus.head_valid), 0);
    chk("same_cyc_addr", bus.head_addr, 0);
    do_flush();

    // violation
    alloc(1'b0, 64'h40, 5'd1);
    tick();
    alloc(1'b1, 64'h44, 5'd2);
    tick();
    addr_wb(5'd2, 64'h80);
    ldx(5'd2);
    tick();
    chk("pre_viol", 64'(bus.viol_valid), 0);
    addr_wb(5'd1, 64'h80);
    tick();
    chk("viol_v", 64'(bus.viol_valid), 1);
    chk("viol_pc", bus.viol_pc, 64'h44);
    chk("viol_rob", 64'(bus.viol_rob), 2);
    chk("viol_cnt", 64'(bus.count), 2);
    tick();
    chk("viol_drop", 64'(bus.viol_valid), 0);
    do_flush();

    alloc(1'b0, 64'h40, 5'd1);
    tick();
    alloc(1'b1, 64'h44, 5'd2);
    tick();
    addr_wb(5'd2, 64'h80);
    ldx(5'd2);
    tick();
    addr_wb(5'd1, 64'h88);
    tick();
    chk("noviol_addr", 64'(bus.viol_valid), 0);
    do_flush();

    alloc(1'b0, 64'h40, 5'd1);
    tick();
    alloc(1'b1, 64'h44, 5'd2);
    tick();
    addr_wb(5'd2, 64'h80);
    tick();
    addr_wb(5'd1, 64'h80);
    ldx(5'd2);
    tick();
    chk("noviol_samecyc", 64'(bus.viol_valid), 0);
    do_flush();

    // oldest younger load wins; older load ignored
    alloc(1'b1, 64'h48, 5'd7);
    tick();
    alloc(1'b0, 64'h4c, 5'd4);
    tick();
    alloc(1'b1, 64'h50, 5'd5);
    tick();
    alloc(1'b1, 64'h54, 5'd6);
    tick();
    addr_wb(5'd7, 64'h200);
    ldx(5'd7);
    tick();
    addr_wb(5'd5, 64'h200);
    ldx(5'd5);
    tick();
    addr_wb(5'd6, 64'h200);
    ldx(5'd6);
    tick();
    addr_wb(5'd4, 64'h200);
    tick();
    chk("old_v", 64'(bus.viol_valid), 1);
    chk("old_rob", 64'(bus.viol_rob), 5);
    chk("old_pc", bus.viol_pc, 64'h50);
    do_flush();

    // simultaneous alloc+retire, then flush priority
    alloc(1'b0, 64'h60, 5'd10);
    tick();
    alloc(1'b0, 64'h64, 5'd11);
    tick();
    alloc(1'b0, 64'h68, 5'd12);
    tick();
    alloc(1'b1, 64'h6c, 5'd13);
    tick();
    alloc(1'b1, 64'h70, 5'd14);
    tick();
    addr_wb(5'd10, 64'h10);
    val_wb(5'd10, 64'h1);
    tick();
    addr_wb(5'd11, 64'h11);
    val_wb(5'd11, 64'h2);
    tick();
    addr_wb(5'd13, 64'h300);
    ldx(5'd13);
    tick();
    chk("c5_count", 64'(bus.count), 5);
    chk("c5_hrob", 64'(bus.head_rob), 10);
    alloc(1'b1, 64'h74, 5'd15);
    bus.retire = 1'b1;
    tick();
    chk("ar_count", 64'(bus.count), 5);
    chk("ar_hrob", 64'(bus.head_rob), 11);
    chk("ar_hv", 64'(bus.head_valid), 1);
    bus.flush = 1'b1;
    alloc(1'b1, 64'h78, 5'd16);
    bus.retire = 1'b1;
    addr_wb(5'd12, 64'h300);
    tick();
    chk("fl_count", 64'(bus.count), 0);
    chk("fl_hv", 64'(bus.head_valid), 0);
    chk("fl_viol", 64'(bus.viol_valid), 0);
    chk("fl_hrob", 64'(bus.head_rob), 0);

    // wrap: 20 stores, up to 12 in flight across the index wrap
    nxt    = 0;
    ret_n  = 0;
    mcnt   = 0;
    pend   = -1;
    wbdone = 0;
    cyc    = 0;
    while (ret_n < 20 && cyc < 100) begin
      do_al  = (nxt < 20) && (mcnt < 16);
      do_ret = (cyc >= 12) && (ret_n < wbdone);
      if (do_al) begin
        alloc(1'b0, 64'h2000 + 64'(4 * nxt), 5'(nxt));
      end
      if (pend >= 0) begin
        addr_wb(5'(pend), 64'h3000 + 64'(pend));
        val_wb(5'(pend), 64'(pend));
      end
      if (do_ret) begin
        chk("wrap_hrob", 64'(bus.head_rob), 64'(ret_n));
        chk("wrap_hpc", bus.head_pc, 64'h2000 + 64'(4 * ret_n));
        chk("wrap_hv", 64'(bus.head_valid), 1);
        bus.retire = 1'b1;
      end
      tick();
      if (pend >= 0) wbdone = pend + 1;
      pend = do_al ? nxt : -1;
      if (do_al) begin
        nxt++;
        mcnt++;
      end
      if (do_ret) begin
        ret_n++;
        mcnt--;
      end
      chk("wrap_count", 64'(bus.count), 64'(mcnt));
      cyc++;
    end
    chk("wrap_done", 64'(ret_n), 20);
    chk("wrap_empty", 64'(bus.count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
